// File: rtl/i2s_tx_sequencer.sv
// I2S (Philips format) transmit sequencer: single-entry sample buffer feeding a
// slot-wide serializer with a programmable sclk divider and sticky underflow irq.
//
// state | meaning
// IDLE  | outputs parked low, divider held at 0, buffer contents retained
// PRIME | waiting for the first (left) sample to land in the buffer
// RUN   | framing; buffer refilled whenever it empties
// DRAIN | finishing the current frame, no new samples accepted
module i2s_tx_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  aud_mclk,
    input  logic                  aud_mrst,
    input  logic                  en,
    input  logic [7:0]            sclk_div,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic                  sclk_out,
    output logic                  lrclk_out,
    output logic                  sdata_0_out,
    output logic                  irq,
    input  logic                  irq_clr
);

    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam logic [BW-1:0] B_LAST  = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] B_RIGHT = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] B_LR_LO = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] B_LR_HI = BW'(2 * SLOT_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              div_q;
    logic [7:0]              cnt_q;
    logic                    sclk_q;
    logic [BW-1:0]           b_q;
    logic [BW-1:0]           b_next;
    logic [SLOT_WIDTH-1:0]   shift_q;
    logic [SLOT_WIDTH-1:0]   load_word;
    logic                    buf_full_q;
    logic [DATA_WIDTH-1:0]   buf_q;
    logic                    irq_q;

    logic                    active;
    logic                    tick;
    logic                    fall;
    logic                    load_edge;
    logic                    underflow;
    logic                    accept;
    logic                    run_entry;

    always_comb begin
        active    = (state_q == RUN) || (state_q == DRAIN);
        tick      = active && (cnt_q == (div_q - 8'd1));
        fall      = tick && sclk_q;
        b_next    = (b_q == B_LAST) ? '0 : (b_q + BW'(1));
        load_edge = fall && ((b_next == '0) || (b_next == B_RIGHT));
        underflow = load_edge && !buf_full_q;
        s_tready  = ((state_q == PRIME) || (state_q == RUN)) && !buf_full_q;
        accept    = s_tvalid && s_tready;
        // Sample is left-justified in the slot; the tail of the slot is zero pad.
        load_word = '0;
        load_word[SLOT_WIDTH-1 -: DATA_WIDTH] = buf_q;
    end

    always_comb begin
        state_d   = state_q;
        run_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = PRIME;
            end
            PRIME: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (buf_full_q) begin
                    state_d   = RUN;
                    run_entry = 1'b1;
                end
            end
            RUN: begin
                if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                if (fall && (b_next == B_LAST)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aud_mclk) begin
        if (aud_mrst) begin
            state_q    <= IDLE;
            div_q      <= 8'd1;
            cnt_q      <= '0;
            sclk_q     <= 1'b0;
            b_q        <= B_LAST;
            shift_q    <= '0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (underflow) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end

            if (accept) begin
                buf_full_q <= 1'b1;
                buf_q      <= s_tdata;
            end else if (load_edge) begin
                buf_full_q <= 1'b0;
            end

            // Any path into IDLE parks the serializer so the outputs drop the same cycle.
            if (state_d == IDLE) begin
                cnt_q   <= '0;
                sclk_q  <= 1'b0;
                b_q     <= B_LAST;
                shift_q <= '0;
            end else if (run_entry) begin
                div_q   <= (sclk_div == 8'd0) ? 8'd1 : sclk_div;
                cnt_q   <= '0;
                sclk_q  <= 1'b0;
                b_q     <= B_LAST;
                shift_q <= '0;
            end else if (tick) begin
                cnt_q  <= '0;
                sclk_q <= ~sclk_q;
                if (sclk_q) begin
                    b_q <= b_next;
                    if (load_edge) begin
                        shift_q <= buf_full_q ? load_word : '0;
                    end else begin
                        shift_q <= {shift_q[SLOT_WIDTH-2:0], 1'b0};
                    end
                end
            end else if (active) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign sclk_out    = sclk_q;
    assign lrclk_out   = active && (b_q >= B_LR_LO) && (b_q <= B_LR_HI);
    assign sdata_0_out = shift_q[SLOT_WIDTH-1];
    assign irq         = irq_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: expected waveform is computed per mclk cycle from
// elapsed time since RUN entry (divider, bit index, slot index) and a sample list.
module tb_i2s_tx_sequencer;

    logic        aud_mclk = 1'b0;
    logic        aud_mrst;
    logic        en;
    logic [7:0]  sclk_div;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        sclk_out;
    logic        lrclk_out;
    logic        sdata_0_out;
    logic        irq;
    logic        irq_clr;

    i2s_tx_sequencer #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
        .aud_mclk    (aud_mclk),
        .aud_mrst    (aud_mrst),
        .en          (en),
        .sclk_div    (sclk_div),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .sclk_out    (sclk_out),
        .lrclk_out   (lrclk_out),
        .sdata_0_out (sdata_0_out),
        .irq         (irq),
        .irq_clr     (irq_clr)
    );

    always #5 aud_mclk = ~aud_mclk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          cyc_en = 0;
    int          dv = 2;
    int          t_end;
    int          drop_t;
    int          win_lo;
    int          win_hi;
    int          fidx;
    bit          sess = 1'b0;
    bit          m_irq = 1'b0;
    logic [23:0] feed [0:31];
    bit          under [0:31];

    // RUN starts three cycles after the cycle in which en is first driven high
    // (IDLE->PRIME, accept, buffer valid -> RUN).
    function automatic int tnow();
        return cyc - (cyc_en + 3);
    endfunction

    function automatic logic [23:0] slot_val(input int n);
        int skipped;
        skipped = 0;
        if (under[n]) return 24'd0;
        for (int i = 0; i < n; i++) if (under[i]) skipped++;
        return feed[n - skipped];
    endfunction

    function automatic logic [2:0] model_out(input int t);
        int k, b, n, pos;
        logic [23:0] v;
        logic sc, lr, sd;
        if (!sess || t < 0 || t >= t_end) return 3'b000;
        k  = t / (2 * dv);
        sc = ((t / dv) % 2) == 1;
        b  = (k + 63) % 64;
        lr = (b >= 31) && (b <= 62);
        sd = 1'b0;
        if (k > 0) begin
            n   = (k - 1) / 32;
            pos = (k - 1) % 32;
            if (pos < 24 && n < 32) begin
                v  = slot_val(n);
                sd = v[23 - pos];
            end
        end
        return {sc, lr, sd};
    endfunction

    function automatic bit underflow_at(input int t);
        int k;
        if (!sess || t <= 0 || t >= t_end || (t % (2 * dv)) != 0) return 1'b0;
        k = t / (2 * dv);
        if (((k - 1) % 32) != 0 || ((k - 1) / 32) >= 32) return 1'b0;
        return under[(k - 1) / 32];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d t=%0d observed=%0b expected=%0b", tag, cyc, tnow(), obs, exp);
        end
    endtask

    task automatic step();
        int t;
        logic [2:0] e;
        logic acc, clr_s, rst_s;
        t = tnow();
        s_tvalid = !(sess && t >= win_lo && t <= win_hi);
        s_tdata  = feed[fidx];
        @(negedge aud_mclk);
        e = model_out(t);
        check("sclk", sclk_out, e[2]);
        check("lrclk", lrclk_out, e[1]);
        check("sdata", sdata_0_out, e[0]);
        check("irq", irq, m_irq);
        if (!sess || t < -2 || t == -1 || t > drop_t) check("tready_low", s_tready, 1'b0);
        else if (t == -2) check("tready_prime", s_tready, 1'b1);
        acc   = s_tvalid && s_tready;
        clr_s = irq_clr;
        rst_s = aud_mrst;
        @(posedge aud_mclk);
        #1;
        cyc++;
        if (acc) fidx++;
        if (rst_s) m_irq = 1'b0;
        else if (underflow_at(tnow())) m_irq = 1'b1;
        else if (clr_s) m_irq = 1'b0;
    endtask

    task automatic run_to(input int tt);
        while (tnow() < tt) step();
    endtask

    task automatic new_session_data();
        for (int i = 0; i < 32; i++) begin
            feed[i]  = 24'($urandom);
            under[i] = 1'b0;
        end
        fidx   = 0;
        win_lo = -100;
        win_hi = -200;
        drop_t = 1 << 30;
        t_end  = 1 << 30;
    endtask

    initial begin
        aud_mrst = 1'b1;
        en       = 1'b0;
        irq_clr  = 1'b0;
        sclk_div = 8'd2;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        new_session_data();
        feed[0] = 24'hA5A5A5;
        feed[1] = 24'h3C3C3C;

        @(posedge aud_mclk);
        #1;
        cyc = 1;
        repeat (10) step();
        aud_mrst = 1'b0;
        repeat (3) step();

        // Session 1: D=2, right slots 5 and 9 starved, en dropped at frame 5 b=10.
        dv = 2;
        under[5] = 1'b1;
        under[9] = 1'b1;
        win_lo = 511;
        win_hi = 649;
        en = 1'b1;
        cyc_en = cyc;
        sess = 1'b1;
        run_to(664);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        win_lo = 1023;
        win_hi = 1161;
        run_to(1155);
        irq_clr = 1'b1;   // lands on the slot-9 underflow edge
        step();
        irq_clr = 1'b0;
        run_to(1324);
        en = 1'b0;
        drop_t = 1324;
        t_end = 1536;
        run_to(1556);
        sess = 1'b0;
        repeat (5) step();

        // Session 2: sclk_div=0 -> D=1, div change ignored, reset at frame 1 b=40.
        new_session_data();
        dv = 1;
        sclk_div = 8'd0;
        en = 1'b1;
        cyc_en = cyc;
        sess = 1'b1;
        run_to(100);
        sclk_div = 8'd5;
        run_to(210);
        aud_mrst = 1'b1;
        step();
        sess = 1'b0;
        repeat (2) step();

        // Session 3: fresh start after reset begins with a left sample.
        new_session_data();
        dv = 2;
        sclk_div = 8'd2;
        aud_mrst = 1'b0;
        cyc_en = cyc;
        sess = 1'b1;
        run_to(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_sequencer.md
I2S_TX_SEQUENCER -- requirements
Module: i2s_tx_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 24: audio sample width in bits, legal range 8..32.
REQ-002 Parameter SLOT_WIDTH, default 32: sclk bits per channel slot, at least DATA_WIDTH.
REQ-003 aud_mclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 aud_mrst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  transmit enable, level.
REQ-006 sclk_div  in  8  sclk half-period in aud_mclk cycles; 0 treated as 1.
REQ-007 s_tdata  in  DATA_WIDTH  sample; stream order is L,R,L,R... with the first sample after enable being left.
REQ-008 s_tvalid  in  1  sample valid.
REQ-009 s_tready  out  1  sample accepted on a cycle where s_tvalid=1 and s_tready=1.
REQ-010 sclk_out  out  1  serial bit clock.
REQ-011 lrclk_out  out  1  word select; 0 = left, 1 = right.
REQ-012 sdata_0_out  out  1  serial data, MSB first.
REQ-013 irq  out  1  sticky underflow interrupt.
REQ-014 irq_clr  in  1  clears irq.

Function
REQ-015 States: IDLE, PRIME, RUN, DRAIN.
REQ-016 IDLE to PRIME when en=1.
REQ-017 PRIME to RUN on the cycle after the sample buffer becomes valid.
REQ-018 PRIME to IDLE when en=0.
REQ-019 On entry to RUN: latch sclk_div (0 maps to 1) as D, set the divider count to 0, sclk_out=0, and set the bit index b=2*SLOT_WIDTH-1.
REQ-020 Divider in RUN/DRAIN: count 0..D-1; at count D-1, sclk_out toggles and the count wraps to 0; sclk period is 2*D aud_mclk cycles.
REQ-021 On each sclk 1->0 toggle ("falling edge"), b advances modulo 2*SLOT_WIDTH; sclk_out, lrclk_out and sdata_0_out all update in that same cycle.
REQ-022 lrclk_out = 1 for b in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2], else 0; this gives the I2S one-bit lead of lrclk over the MSB.
REQ-023 Shift register width is SLOT_WIDTH.
REQ-024 Load at the falling edge where b becomes 0 (left) or SLOT_WIDTH (right): load {buffer, zero pad}, consume the buffer.
REQ-025 If the buffer is empty at a load edge: load all zeros and set irq.
REQ-026 At all other falling edges the shift register shifts left, filling with 0.
REQ-027 sdata_0_out = shift register MSB.
REQ-028 Sample buffer is a single entry: s_tready = (state is PRIME or RUN) and buffer empty.
REQ-029 An accept fills the buffer on the next edge.
REQ-030 A consume and an accept never occur in the same cycle, because s_tready=0 while the buffer is full.
REQ-031 RUN to DRAIN when en=0.
REQ-032 DRAIN continues transmitting with s_tready=0.
REQ-033 At the falling edge where b becomes 2*SLOT_WIDTH-1, DRAIN goes to IDLE.
REQ-034 Re-asserting en during DRAIN has no effect until IDLE is reached.
REQ-035 In IDLE: sclk_out, lrclk_out and sdata_0_out are all 0, and the divider is held at 0.
REQ-036 The buffer contents are retained in IDLE.
REQ-037 irq is set by underflow and cleared by irq_clr; if both occur in the same cycle, set wins.
REQ-038 sclk_div changes during RUN are ignored until the next entry to RUN.

Reset
REQ-039 While aud_mrst=1 at a clock edge: state=IDLE, divider count=0, b=2*SLOT_WIDTH-1, shift register=0, buffer empty.
REQ-040 While aud_mrst=1 at a clock edge: all outputs 0 (sclk_out, lrclk_out, sdata_0_out, s_tready, irq).
REQ-041 Reset mid-frame aborts immediately, with no drain.
REQ-042 Reset overrides en, irq_clr and s_tvalid.

Verification (DATA_WIDTH=24, SLOT_WIDTH=32, sclk_div=2)
REQ-043 Apply reset for 10 cycles -> all outputs 0, state IDLE, s_tready=0.
REQ-044 Set en=1 and supply L=0xA5A5A5, R=0x3C3C3C with continuous valid.
  - Required: sclk period 4 mclk, frame 256 mclk.
  - Required: lrclk falls 1 sclk before the left MSB.
  - Required: sdata = 24 data bits then 8 zeros per slot; irq stays 0.
REQ-045 Withhold the right sample -> the right slot is all zeros, irq=1 and sticky; pulse irq_clr -> irq=0; assert irq_clr on an underflow edge -> irq stays 1.
REQ-046 Drop en at b=10 -> the frame completes through b=63, then outputs go to 0 and s_tready stays 0 from the en drop onward.
REQ-047 Set sclk_div=0 -> sclk period 2 mclk; change sclk_div to 5 mid-RUN -> period unchanged.
REQ-048 Assert aud_mrst at b=40 -> the next cycle has all outputs 0; a fresh enable restarts with the left sample.
